// File: rtl/ws_result_collector.sv
// ws_result_collector
//   Drains the skewed partial sums leaving the bottom edge of a weight-stationary
//   array and de-skews them into whole result vectors. The vectors go into a small
//   FIFO so the downstream consumer can apply backpressure.
//   Column c arrives c cycles after column 0. It is delayed by (row-1-c) stages so
//   that every column lines up with col0_valid delayed by row-1 stages.
//
//   Optional feature: define WS_COLLECTOR_RELU_EN to clamp negative (signed) words
//   to zero before the FIFO write. Latency is the same in both builds.
//
// Ports
//   clk, rst     clock; asynchronous active-low reset
//   start        one-cycle tile request, only honoured in IDLE
//   num_rows     vectors expected in the tile, sampled when start is accepted
//   col0_valid   Result_in[0] carries a valid word this cycle
//   Result_in    skewed words, one per column
//   out_ready    consumer accepts out_data
//   out_valid    FIFO non-empty; out_data holds the head vector
//   out_data     aligned vector at the FIFO head (zero while empty)
//   busy         FSM not IDLE
//   done         one-cycle pulse at tile completion
//   overflow     sticky: an aligned vector was dropped on a full FIFO
module ws_result_collector #(
  parameter int out_word_size = 16,
  parameter int row           = 3,
  parameter int fifo_depth    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [15:0]                           num_rows,
  input  logic                                  col0_valid,
  input  logic [0:row-1][out_word_size-1:0]     Result_in,
  input  logic                                  out_ready,
  output logic                                  out_valid,
  output logic [0:row-1][out_word_size-1:0]     out_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);
  localparam int PW = $clog2(fifo_depth);
  localparam int CW = $clog2(fifo_depth + 1);

  typedef logic [0:row-1][out_word_size-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  logic   aligned_v;
  vec_t   aligned_vec, wr_vec;

  // ---------------- de-skew ----------------
  generate
    if (row > 1) begin : g_vpipe
      logic [row-2:0] vld_pipe_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_pipe_q <= '0;
        else begin
          vld_pipe_q[0] <= col0_valid;
          for (int i = 1; i < row - 1; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
      end
      assign aligned_v = vld_pipe_q[row-2];
    end else begin : g_vnopipe
      assign aligned_v = col0_valid;
    end

    for (genvar c = 0; c < row; c++) begin : g_col
      localparam int S = row - 1 - c;
      if (S > 0) begin : g_dly
        logic [S-1:0][out_word_size-1:0] sh_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) sh_q <= '0;
          else begin
            sh_q[0] <= Result_in[c];
            for (int i = 1; i < S; i++) sh_q[i] <= sh_q[i-1];
          end
        end
        assign aligned_vec[c] = sh_q[S-1];
      end else begin : g_nodly
        // last column already lines up with the delayed valid
        assign aligned_vec[c] = Result_in[c];
      end
`ifdef WS_COLLECTOR_RELU_EN
      assign wr_vec[c] = aligned_vec[c][out_word_size-1] ? '0 : aligned_vec[c];
`else
      assign wr_vec[c] = aligned_vec[c];
`endif
    end
  endgenerate

  // ---------------- FIFO + control ----------------
  state_t          state_q;
  logic [15:0]     rem_q;
  logic            done_q, ovf_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  vec_t            mem_q [fifo_depth];
  logic            rd_en, wr_en, drop, full, ev;

  always_comb begin
    out_valid = (cnt_q != '0);
    rd_en     = out_valid && out_ready;
    full      = (cnt_q == CW'(fifo_depth));
    ev        = aligned_v && (state_q == COLLECT);
    // a full FIFO still takes the vector when the head leaves this same cycle
    wr_en     = ev && (!full || rd_en);
    drop      = ev && full && !rd_en;
    cnt_d     = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      case (state_q)
        IDLE: if (start) begin
          ovf_q <= 1'b0;
          if (num_rows != 16'd0) begin
            rem_q   <= num_rows;
            state_q <= COLLECT;
          end else begin
            done_q  <= 1'b1;
          end
        end
        COLLECT: if (aligned_v) begin
          // dropped vectors still count toward the tile
          rem_q <= rem_q - 16'd1;
          if (drop) ovf_q <= 1'b1;
          if (rem_q == 16'd1) state_q <= DRAIN;
        end
        DRAIN: if (cnt_d == '0) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
